// File: rtl/io_uart_if.sv
// CPU I/O bus as seen by the UART: read/write strobes, address, write data
// and the combinational read data returned to the core.
interface io_uart_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;

  // Core side drives strobes, address and write data.
  modport master (
    output io_rd,
    output io_wr,
    output mem_addr,
    output dout,
    input  io_din
  );

  // Peripheral side answers with read data.
  modport slave (
    input  io_rd,
    input  io_wr,
    input  mem_addr,
    input  dout,
    output io_din
  );
endinterface

// File: rtl/io_uart.sv
// UART peripheral on the CPU I/O bus: TX holding register feeding a shift
// FSM, a two-flop synchronised RX deserialiser feeding a small FIFO, and a
// status register with sticky overrun / framing error flags.
module io_uart #(
  parameter int unsigned DIV       = 104,
  parameter int unsigned RX_DEPTH  = 8,
  parameter logic [15:0] ADDR_DATA = 16'h1000,
  parameter logic [15:0] ADDR_STAT = 16'h2000
) (
  input  logic       clk,
  input  logic       resetq,
  io_uart_if.slave   bus,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int CW   = $clog2(DIV);
  localparam int PW   = $clog2(RX_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CW-1:0]   DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0]   HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] FULL    = CNTW'(RX_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_t;

  // ---------------------------------------------------------------- decode
  logic sel_data, sel_stat;
  logic wr_data, rd_data, rd_stat;

  assign sel_data = (bus.mem_addr == ADDR_DATA);
  assign sel_stat = (bus.mem_addr == ADDR_STAT);
  assign wr_data  = bus.io_wr & sel_data;
  assign rd_data  = bus.io_rd & sel_data;
  assign rd_stat  = bus.io_rd & sel_stat;

  // ---------------------------------------------------------------- TX path
  ser_state_t    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          hold_full;
  logic [7:0]    hold_data;

  // Holding register load and TX shift FSM; uart_tx is registered.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      uart_tx   <= 1'b1;
    end else begin
      // Writes while the holding register is occupied are discarded.
      if (wr_data && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= bus.dout[7:0];
      end
      case (tx_state)
        ST_IDLE: begin
          if (hold_full) begin
            tx_shift  <= hold_data;
            hold_full <= 1'b0;
            tx_cnt    <= DIV_M1;
            uart_tx   <= 1'b0;
            tx_state  <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= DIV_M1;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= DIV_M1;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx_shift <= tx_shift >> 1;
              uart_tx  <= tx_shift[1];
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == '0) begin
            // Chain straight into the next start bit so the stop bit is
            // exactly DIV clocks when a byte is already waiting.
            if (hold_full) begin
              tx_shift  <= hold_data;
              hold_full <= 1'b0;
              tx_cnt    <= DIV_M1;
              uart_tx   <= 1'b0;
              tx_state  <= ST_START;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic rx_s1, rx_s2, rx_prev;
  logic rx_line;

  assign rx_line = rx_s2;

  // Two-flop synchroniser plus one history flop for falling-edge detect.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  ser_state_t    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_stop_tick;

  assign rx_stop_tick = (rx_state == ST_STOP) && (rx_cnt == '0);

  // RX deserialiser: start detect needs a high-to-low transition, so after
  // a framing error the line must return high before the next frame.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_line) begin
            rx_cnt   <= HALF_M1;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == '0) begin
            if (rx_line) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_cnt   <= DIV_M1;
              rx_bit   <= '0;
              rx_state <= ST_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_line, rx_shift[7:1]};
            rx_cnt   <= DIV_M1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt == '0) rx_state <= ST_IDLE;
          else              rx_cnt   <= rx_cnt - 1'b1;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]      fifo_mem [RX_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] rx_count;
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop;

  assign fifo_empty = (rx_count == '0);
  assign fifo_full  = (rx_count == FULL);
  assign push_req   = rx_stop_tick && rx_line;
  assign pop        = rd_data && !fifo_empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts.
  assign push       = push_req && (!fifo_full || pop);

  // FIFO storage write.
  // NOTE: storage has no reset; occupancy is tracked by the reset pointers
  // and count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_shift;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      rx_count <= rx_count + 1'b1;
      else if (!push && pop) rx_count <= rx_count - 1'b1;
    end
  end

  // ---------------------------------------------------------------- status
  logic ovr, ferr;

  // Sticky error flags: cleared by a status read, a same-cycle set wins.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= (ovr  && !rd_stat) || (push_req && fifo_full && !pop);
      ferr <= (ferr && !rd_stat) || (rx_stop_tick && !rx_line);
    end
  end

  logic tx_ready, tx_idle, rx_avail;
  logic [15:0] rdata;

  assign tx_ready = !hold_full;
  assign tx_idle  = !hold_full && (tx_state == ST_IDLE);
  assign rx_avail = !fifo_empty;

  // Combinational read mux; the core captures io_din at the strobe edge.
  // NOTE: rdata gets a default first so no path leaves it unassigned.
  always_comb begin
    rdata = '0;
    if (sel_data) begin
      if (!fifo_empty) rdata = {8'h00, fifo_mem[rd_ptr]};
    end else if (sel_stat) begin
      rdata = {11'b0, ferr, ovr, tx_idle, rx_avail, tx_ready};
    end
  end

  assign bus.io_din = rdata;

endmodule

// File: tb/tb_io_uart.sv
// Scoreboarded bench for io_uart: directed bus reads push expected read data,
// TX writes push expected serial bytes; two monitors pop and compare.
module tb_io_uart;

  localparam int          DIV    = 8;
  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h2000;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  logic clk     = 1'b0;
  logic resetq  = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx;

  io_uart_if bus ();

  io_uart #(
    .DIV       (DIV),
    .RX_DEPTH  (4),
    .ADDR_DATA (A_DATA),
    .ADDR_STAT (A_STAT)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       exp_rd [$];
  logic [7:0] exp_tx [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read monitor: every sampled read strobe pops one expected value.
  always @(negedge clk) begin
    if (resetq && bus.io_rd === 1'b1) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got %h expected no read", bus.io_din);
      end else begin
        exp_t e;
        e = exp_rd.pop_front();
        check(e.name, bus.io_din, e.val);
      end
    end
  end

  // TX monitor: decode each frame mid-bit and compare with the next byte.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (resetq && uart_tx === 1'b0) begin
        repeat (DIV / 2 - 1) @(negedge clk);
        check("tx_start_bit", {15'b0, uart_tx}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        check("tx_stop_bit", {15'b0, uart_tx}, 16'h0001);
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got %h expected no frame", b);
        end else begin
          check("tx_byte", {8'h00, b}, {8'h00, exp_tx.pop_front()});
        end
      end
    end
  end

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    x.name = nm;
    x.val  = e;
    exp_rd.push_back(x);
    bus.mem_addr = a;
    bus.io_rd    = 1'b1;
    @(posedge clk);
    #1;
    bus.io_rd = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.mem_addr = a;
    bus.dout     = d;
    bus.io_wr    = 1'b1;
    @(posedge clk);
    #1;
    bus.io_wr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = d[i];
      repeat (DIV) @(posedge clk);
    end
    #1 uart_rx = stop_bit;
    repeat (DIV) @(posedge clk);
    #1 uart_rx = 1'b1;
  endtask

  // Watchdog: the run is a few thousand cycles.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    bus.mem_addr = '0;
    bus.dout     = '0;
    repeat (3) @(posedge clk);
    #1 resetq = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and address decode.
    check("reset_uart_tx", {15'b0, uart_tx}, 16'h0001);
    rd(A_STAT, 16'h0005, "stat_after_reset");
    rd(A_DATA, 16'h0000, "data_empty_after_reset");
    rd(16'h1001, 16'h0000, "unmapped_read");
    wr(16'h1001, 16'h00AA);
    wr(16'h0000, 16'h00BB);
    rd(A_STAT, 16'h0005, "stat_after_unmapped_writes");

    // Single byte: tx_idle returns exactly after the 80-clock frame.
    exp_tx.push_back(8'h55);
    wr(A_DATA, 16'h1255);
    repeat (79) @(posedge clk);
    rd(A_STAT, 16'h0001, "stat_last_stop_clock");
    rd(A_STAT, 16'h0005, "stat_tx_done");

    // Back-to-back bytes; third write while holding is full is dropped.
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h3C);
    wr(A_DATA, 16'h00A5);
    wr(A_DATA, 16'h003C);
    wr(A_DATA, 16'h0077);
    rd(A_STAT, 16'h0000, "stat_holding_full");
    repeat (180) @(posedge clk);
    rd(A_STAT, 16'h0005, "stat_after_two_frames");

    // Single RX byte.
    send_byte(8'hC3, 1'b1);
    repeat (4) @(posedge clk);
    rd(A_STAT, 16'h0007, "stat_rx_avail");
    rd(A_DATA, 16'h00C3, "rx_data_c3");
    rd(A_STAT, 16'h0005, "stat_rx_drained");

    // Overrun: fifth byte dropped, flags clear on first status read.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (4) @(posedge clk);
    rd(A_STAT, 16'h000F, "stat_overrun");
    rd(A_STAT, 16'h0007, "stat_overrun_cleared");
    for (int i = 1; i <= 4; i++) rd(A_DATA, 16'(i), "rx_fifo_order");
    rd(A_DATA, 16'h0000, "rx_fifo_empty_read");
    rd(A_STAT, 16'h0005, "stat_fifo_drained");

    // Framing error: no push, ferr set then cleared.
    send_byte(8'h5A, 1'b0);
    repeat (4) @(posedge clk);
    rd(A_STAT, 16'h0015, "stat_framing_error");
    rd(A_STAT, 16'h0005, "stat_ferr_cleared");
    rd(A_DATA, 16'h0000, "ferr_no_push");

    // Short glitch: false start, nothing logged.
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    rd(A_STAT, 16'h0005, "stat_after_glitch");
    rd(A_DATA, 16'h0000, "glitch_no_push");

    // Receiver still works after the glitch.
    send_byte(8'h7E, 1'b1);
    repeat (4) @(posedge clk);
    rd(A_STAT, 16'h0007, "stat_rx_after_glitch");
    rd(A_DATA, 16'h007E, "rx_data_7e");

    repeat (10) @(posedge clk);
    check("rd_queue_drained", 16'(exp_rd.size()), 16'h0000);
    check("tx_queue_drained", 16'(exp_tx.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
